// File: rtl/compression_lane_arbiter.sv
// compression_lane_arbiter
// Round-robin arbiter that grants one of N compression lanes at a time and
// forwards its beats through a single registered output stage.
// Build option: COMPRESSION_ARB_BURST_LOCK_EN
//   defined   -> a grant is held until req_last or MAX_BURST beats
//   undefined -> a grant lasts exactly one beat (per-beat interleaving)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; arbitrate among valid lanes, load grant on exit
// BURST  | one lane owns the output; beats flow until the burst ends
module compression_lane_arbiter #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [N-1:0]      req_valid_i,
    input  logic [N*W-1:0]    req_data_i,
    input  logic [N-1:0]      req_last_i,
    output logic [N-1:0]      req_ready_o,
    output logic              out_valid_o,
    output logic [W-1:0]      out_data_o,
    output logic              out_last_o,
    output logic [ID_W-1:0]   out_src_o,
    input  logic              out_ready_i,
    output logic [N-1:0]      grant_o,
    output logic              busy_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    localparam logic [7:0]   BEAT_CAP  = 8'(MAX_BURST - 1);
    localparam logic [N-1:0] ONE_HOT_0 = N'(1);

    state_e            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]   gidx_q, gidx_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [ID_W-1:0]   out_src_q, out_src_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic              out_slot_free;
    logic [N-1:0]      ready;
    logic              xfer;
    logic              burst_end;

    // The output slot can take a new beat when empty or draining this cycle.
    assign out_slot_free = ~out_valid_q | out_ready_i;
    assign ready         = grant_q & {N{out_slot_free}};
    assign xfer          = |(req_valid_i & ready);

`ifdef COMPRESSION_ARB_BURST_LOCK_EN
    assign burst_end = xfer & (req_last_i[gidx_q] | (beat_cnt_q == BEAT_CAP));
`else
    assign burst_end = xfer;
`endif

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!win_found && req_valid_i[(int'(last_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = ID_W'((int'(last_q) + k) % N);
            end
        end
    end

    // Next-state logic for the grant FSM and its burst bookkeeping.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_BURST;
                    grant_d    = ONE_HOT_0 << win_idx;
                    gidx_d     = win_idx;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    // Saturate so the counter never wraps, even when the cap is unused.
                    beat_cnt_d = (beat_cnt_q == BEAT_CAP) ? beat_cnt_q : beat_cnt_q + 8'd1;
                end
                if (burst_end) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output register: load on transfer, clear on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_i[int'(gidx_q) * W +: W];
            out_last_d  = req_last_i[gidx_q];
            out_src_d   = gidx_q;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; reset aborts any burst and drops a pending beat.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_q      <= ID_W'(N - 1);
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign req_ready_o = ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == S_BURST);

endmodule

// File: tb/tb_compression_lane_arbiter.sv
// Directed bench for compression_lane_arbiter with a beat scoreboard.
// Expectations follow COMPRESSION_ARB_BURST_LOCK_EN when it is defined.
module tb_compression_lane_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int ID_W = 2;
`ifdef COMPRESSION_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [ID_W-1:0] out_src;
    logic            out_ready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;

    compression_lane_arbiter #(.N(N), .W(W), .ID_W(ID_W), .MAX_BURST(16)) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    logic [32:0] lane_q[N][$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          hs_count = 0;

    function automatic logic [31:0] mk(input int lane, input int seq);
        return 32'((lane << 16) | seq);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int src, input int seq, input logic last, input int gap);
        exp_t e;
        e.src  = 2'(src);
        e.data = mk(src, seq);
        e.last = last;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic load(input int lane, input int seq, input logic last);
        lane_q[lane].push_back({last, mk(lane, seq)});
    endtask

    task automatic flush_all();
        sb.delete();
        for (int i = 0; i < N; i++) lane_q[i].delete();
    endtask

    task automatic rst_assert();
        rst_n = 1'b0;
        hs_count = 0;
        flush_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic rst_release();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int pend;
        int t;
        t = 0;
        do begin
            @(negedge clk);
            pend = sb.size();
            for (int i = 0; i < N; i++) pend += lane_q[i].size();
            t++;
        end while (pend != 0 && t < budget);
        chk(tag, 64'(pend), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Source model: present queue heads, retire a beat after its handshake.
    initial begin : driver
        logic [N-1:0] acc;
        logic         edge_rst;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            edge_rst = rst_n;
            #1;
            for (int i = 0; i < N; i++) begin
                if (edge_rst && acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                if (lane_q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*W +: W]  = lane_q[i][0][31:0];
                    req_last[i]         = lane_q[i][0][32];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted beat must match the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("out_src", 64'(out_src), 64'(e.src));
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    if (e.gap != 0) chk("beat_gap", 64'(cyc - last_hs), 64'(e.gap));
                end
                last_hs = cyc;
            end
        end
    end

    initial begin : main
        int t;
        // Reset with every lane requesting.
        for (int i = 0; i < N; i++) begin
            load(i, 0, 1'b1);
            push_exp(i, 0, 1'b1, (i == 0) ? 0 : 2);
        end
        repeat (3) @(negedge clk);
        chk("rst_valid_all", 64'(req_valid), 64'hF);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_src", 64'(out_src), 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        rst_release();
        @(negedge clk);
        chk("idle_grant", 64'(grant), 64'h0);
        @(negedge clk);
        chk("first_grant", 64'(grant), 64'h1);
        chk("first_busy", 64'(busy), 64'h1);
        chk("first_ready", 64'(req_ready), 64'h1);
        wait_drain("drain_reset", 60);

        // Round-robin over lanes 0, 2, 3 with single-beat blocks.
        rst_assert();
        for (int s = 0; s < 2; s++) begin
            load(0, s, 1'b1);
            load(2, s, 1'b1);
            load(3, s, 1'b1);
            push_exp(0, s, 1'b1, (s == 0) ? 0 : 2);
            push_exp(2, s, 1'b1, 2);
            push_exp(3, s, 1'b1, 2);
        end
        rst_release();
        wait_drain("drain_rr", 60);

        // Backpressure in the middle of lane 1's traffic.
        rst_assert();
        for (int s = 0; s < 6; s++) begin
            load(1, s, (s == 5));
            push_exp(1, s, (s == 5), 0);
        end
        rst_release();
        repeat (2) @(posedge clk);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(out_valid && hs_count >= 1) && t < 50);
        chk("bp_reached", 64'(out_valid), 64'h1);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_data", 64'(out_data), 64'((sb.size() > 0) ? sb[0].data : 32'hDEAD));
            chk("bp_ready", 64'(req_ready), 64'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("drain_bp", 80);

        // Asynchronous reset while lane 2 is mid-stream.
        rst_assert();
        for (int s = 0; s < 12; s++) load(2, s, (s == 11));
        for (int s = 0; s < 12; s++) push_exp(2, s, (s == 11), 0);
        rst_release();
        t = 0;
        while (!(hs_count >= 7 && out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("arst_reached", 64'(hs_count >= 7), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_grant", 64'(grant), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_req_ready", 64'(req_ready), 64'h0);
        chk("arst_out_data", 64'(out_data), 64'h0);
        repeat (2) @(posedge clk);
        flush_all();
        hs_count = 0;
        load(0, 0, 1'b1);
        load(2, 0, 1'b1);
        push_exp(0, 0, 1'b1, 0);
        push_exp(2, 0, 1'b1, 2);
        rst_release();
        @(negedge clk);
        @(negedge clk);
        chk("arst_next_grant", 64'(grant), 64'h1);
        wait_drain("drain_arst", 60);

        // Lanes 0 and 1 each send one 4-beat block.
        rst_assert();
        for (int s = 0; s < 4; s++) begin
            load(0, s, (s == 3));
            load(1, s, (s == 3));
        end
        if (LOCK) begin
            for (int s = 0; s < 4; s++) push_exp(0, s, (s == 3), (s == 0) ? 0 : 1);
            for (int s = 0; s < 4; s++) push_exp(1, s, (s == 3), (s == 0) ? 2 : 1);
        end else begin
            for (int s = 0; s < 4; s++) begin
                push_exp(0, s, (s == 3), (s == 0) ? 0 : 2);
                push_exp(1, s, (s == 3), 2);
            end
        end
        rst_release();
        wait_drain("drain_alt", 80);

        // Lane 1 streams 40 beats without an end marker.
        rst_assert();
        for (int s = 0; s < 40; s++) begin
            load(1, s, 1'b0);
            if (s == 0) push_exp(1, s, 1'b0, 0);
            else if (LOCK) push_exp(1, s, 1'b0, (s % 16 == 0) ? 2 : 1);
            else push_exp(1, s, 1'b0, 2);
        end
        rst_release();
        wait_drain("drain_cap", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/compression_lane_arbiter.md
COMPRESSION_LANE_ARBITER -- requirements
Module: compression_lane_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesting lanes, 2 to 8.
REQ-002 Parameter W, default 32: data width per lane.
REQ-003 Parameter ID_W, default 2: lane index width, equal to ceil(log2(N)).
REQ-004 Parameter MAX_BURST, default 16: maximum beats per grant, 1 to 256.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 req_valid  in  N  per-lane beat valid.
REQ-008 req_data  in  N*W  per-lane beat; lane i occupies bits [i*W +: W].
REQ-009 req_last  in  N  per-lane end-of-block marker.
REQ-010 req_ready  out  N  per-lane accept.
REQ-011 out_valid  out  1  registered output beat valid.
REQ-012 out_data  out  W  registered output beat.
REQ-013 out_last  out  1  registered end-of-block marker.
REQ-014 out_src  out  ID_W  lane index of the current output beat.
REQ-015 out_ready  in  1  downstream accept.
REQ-016 grant  out  N  one-hot current owner; zero when idle.
REQ-017 busy  out  1  high in BURST state.

Function
REQ-018 FSM states: IDLE and BURST.
REQ-019 In IDLE with any req_valid high, select winner round-robin: first valid lane at or after (last_winner+1) mod N. Load grant, enter BURST next cycle.
REQ-020 In IDLE, grant = 0 and req_ready = 0. Request-to-grant latency is exactly 1 cycle.
REQ-021 req_ready[i] = grant[i] AND (NOT out_valid OR out_ready); combinational; all other lanes 0.
REQ-022 Transfer on lane g when req_valid[g] AND req_ready[g]. Output register loads req_data, req_last and index g, and sets out_valid on the same edge.
REQ-023 Output register clears out_valid when out_valid AND out_ready with no new transfer. Simultaneous drain and load gives back-to-back beats with no bubble.
REQ-024 beat_cnt (8 bits) clears on grant and increments per transfer.
REQ-025 Burst ends on a transfer with req_last high or beat_cnt = MAX_BURST-1. FSM then returns to IDLE, last_winner = g and grant clears.
REQ-026 Each burst is followed by exactly one IDLE cycle.
REQ-027 A granted lane that drops req_valid mid-burst keeps the grant. There is no timeout.
REQ-028 Output register holds its value while out_valid AND NOT out_ready.
REQ-029 out_data is never altered while out_valid is high and not accepted.

Reset
REQ-030 While reset = 0: FSM = IDLE, grant = 0, beat_cnt = 0, last_winner = N-1, out_valid = 0, out_data = 0, out_last = 0, out_src = 0, busy = 0, req_ready = 0.
REQ-031 Reset asserted mid-burst aborts immediately. Any pending output beat is discarded.
REQ-032 After reset release, lane 0 has highest priority for the first arbitration.
REQ-033 Deassertion is synchronised externally. The block requires no extra internal synchroniser.

Configuration
REQ-034 Macro COMPRESSION_ARB_BURST_LOCK_EN.
REQ-035 With COMPRESSION_ARB_BURST_LOCK_EN defined: burst behaviour per REQ-025/REQ-026.
REQ-036 With it undefined: every burst ends after exactly one transfer, regardless of req_last, and MAX_BURST is ignored. Round-robin and one IDLE cycle still apply, giving per-beat interleaving.

Verification
REQ-037 Reset check: reset low for 3 cycles with all req_valid = 4'b1111 -> grant = 0, out_valid = 0. First grant after release = 4'b0001.
REQ-038 Round-robin: lanes 0,2,3 each send 1-beat blocks (req_last = 1) continuously -> out_src sequence 0,2,3,0,2,3, one IDLE cycle between each.
REQ-039 Burst cap (lock on): lane 1 sends 40 beats with req_last low -> bursts of 16, 16, 8 beats. Other lanes interleave between bursts if valid.
REQ-040 Backpressure: out_ready held low 5 cycles mid-burst -> out_data stable, req_ready[g] = 0, no beat lost or duplicated. Data order is preserved on release.
REQ-041 Async reset mid-burst: reset pulses low at beat 7 of lane 2 -> outputs clear without waiting for clk edge. Next grant = lane 0 if valid.
REQ-042 Lock off: lanes 0 and 1 each send 4-beat blocks -> out_src alternates 0,1,0,1 per beat.
